rom_fetch_arbiter: RTL and testbench
====================================

Name: rom_fetch_arbiter

Overview:
Shares the single combinational instruction ROM (16-bit address, 28-bit instruction) between the CPU fetch port and a built-in dump sequencer. The dump sequencer streams a programmed address range out for debug readback and LCD/UART display.
- The CPU has priority.
- A starvation guard guarantees the dump sequencer forward progress.
- The block sits between the CPU fetch stage and the ROM; all ROM reads go through it.

Parameters:
ADDR_W, 16, ROM address width.
DATA_W, 28, instruction width.
MAX_STALL, 4, consecutive dump denials allowed before the dump sequencer is forced a slot (range 1..15).

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
iCpuReq  input  1  CPU fetch request, held until served
iCpuAddress  input  ADDR_W  CPU fetch address
oCpuInstruction  output  DATA_W  registered instruction for CPU
oCpuValid  output  1  oCpuInstruction valid (1-cycle pulse per served request)
oCpuStall  output  1  combinational: CPU request denied this cycle
iDumpStart  input  1  start pulse for dump sequencer
iDumpBase  input  ADDR_W  first dump address, sampled on accepted start
iDumpCount  input  ADDR_W  number of words to dump, sampled on accepted start
oDumpData  output  DATA_W  registered dumped instruction
oDumpAddress  output  ADDR_W  address of oDumpData
oDumpValid  output  1  oDumpData valid, 1-cycle pulse per word
oDumpBusy  output  1  sequencer in RUN
oDumpDone  output  1  1-cycle pulse at end of dump
oDumpChecksum  output  16  running checksum (see Optional Feature)
oRomAddress  output  ADDR_W  combinational address to ROM
iRomInstruction  input  DATA_W  combinational ROM data

Behaviour:
- Reset: all registered outputs 0; FSM to IDLE; starvation counter 0; dump address/remaining 0.
- Dump FSM states and transitions:
  - IDLE -> RUN on iDumpStart with iDumpCount != 0; latch base and count.
  - IDLE -> FINISH on iDumpStart with iDumpCount == 0; no data is emitted.
  - RUN -> FINISH when the last word is granted.
  - FINISH -> IDLE after 1 cycle; oDumpDone = 1 in the cycle after entering FINISH.
  - iDumpStart ignored outside IDLE.
- Dump request: the sequencer requests whenever state == RUN.
- Arbitration, each cycle:
  - Only one requester: it is granted.
  - Both requesting and starve counter < MAX_STALL: CPU granted; counter increments.
  - Both requesting and counter == MAX_STALL: dump granted; oCpuStall = 1; counter cleared.
  - Counter clears whenever dump is granted or dump is not requesting.
- oRomAddress = granted requester's address, else iCpuAddress.
- Latency: a grant in cycle N captures iRomInstruction at edge N+1, giving a valid pulse in cycle N+1.
  - CPU back-to-back fetches yield one instruction per cycle.
  - oCpuValid is never asserted without a prior granted request.
- Dump address increments modulo 2^ADDR_W: 16'hFFFF wraps to 16'h0000.
- Remaining count decrements per granted dump word.
- Reset mid-dump: returns to IDLE immediately; no oDumpDone pulse; checksum cleared.
- oDumpData/oDumpAddress hold their last value when oDumpValid = 0.

Optional Feature:
Macro ROM_DUMP_CHECKSUM_EN.
- Defined: oDumpChecksum accumulates the 16-bit sum of {iRomInstruction[27:16] zero-extended} XOR iRomInstruction[15:0] for every dumped word.
  - Cleared on accepted start.
  - Final value is stable in the oDumpDone cycle and holds until the next start.
- Undefined: oDumpChecksum tied to 16'h0000; no accumulator logic is synthesized.

Test Plan:
For all scenarios, the bench ROM returns {12'hA5A, address}.
- Reset asserted for 2 cycles mid-dump -> all outputs 0, oDumpBusy = 0, no oDumpDone, next start works normally.
- iCpuReq held at addresses 0..7, no dump -> oCpuValid every cycle from the 2nd cycle; oCpuInstruction = 28'hA5A0000..28'hA5A0007 in order; oCpuStall never 1.
- Dump base 16'h0010, count 3, CPU idle:
  - oDumpValid for 3 cycles with addresses 10, 11, 12 and data 28'hA5A0010..12.
  - oDumpDone 1 cycle later.
  - Checksum (EN) = 16'hA5A^16'h0010 + 16'hA5A^16'h0011 + 16'hA5A^16'h0012.
- Dump count 8 with CPU requesting continuously, MAX_STALL = 4 -> pattern of 4 CPU grants, then 1 dump grant with oCpuStall = 1, repeated; all 8 words delivered; CPU data correct after each stall.
- Dump base 16'hFFFE, count 3 -> addresses FFFE, FFFF, 0000 emitted.
- Count 0 start -> no oDumpValid, oDumpDone 2 cycles after start; iDumpStart during RUN ignored (count unchanged).

Source files
------------

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: shares one combinational instruction ROM between the CPU
// fetch port (priority requester) and a dump sequencer that streams a
// programmed address range for debug readback. A starvation counter forces
// a dump slot after MAX_STALL consecutive dump denials.
// Optional feature macro: ROM_DUMP_CHECKSUM_EN (running 16-bit dump checksum).
module rom_fetch_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 28,
   parameter int MAX_STALL = 4
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              iCpuReq,
   input  logic [ADDR_W-1:0] iCpuAddress,
   output logic [DATA_W-1:0] oCpuInstruction,
   output logic              oCpuValid,
   output logic              oCpuStall,
   input  logic              iDumpStart,
   input  logic [ADDR_W-1:0] iDumpBase,
   input  logic [ADDR_W-1:0] iDumpCount,
   output logic [DATA_W-1:0] oDumpData,
   output logic [ADDR_W-1:0] oDumpAddress,
   output logic              oDumpValid,
   output logic              oDumpBusy,
   output logic              oDumpDone,
   output logic [15:0]       oDumpChecksum,
   output logic [ADDR_W-1:0] oRomAddress,
   input  logic [DATA_W-1:0] iRomInstruction
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam logic [3:0] L_MAX_STALL = 4'(MAX_STALL);

   state_t            r_state;
   state_t            w_state_next;
   logic [3:0]        r_starve;
   logic [ADDR_W-1:0] r_dump_ptr;
   logic [ADDR_W-1:0] r_remaining;
   logic [DATA_W-1:0] r_cpu_instr;
   logic              r_cpu_valid;
   logic [DATA_W-1:0] r_dump_data;
   logic [ADDR_W-1:0] r_dump_addr;
   logic              r_dump_valid;
   logic              r_dump_done;

   logic              w_dump_req;
   logic              w_grant_cpu;
   logic              w_grant_dump;
   logic              w_start_ok;

   // Arbitration and dump FSM next-state: CPU wins unless the dump side has
   // been denied MAX_STALL times in a row.
   always_comb begin
      w_state_next = r_state;
      w_dump_req   = (r_state == RUN);
      w_grant_dump = 1'b0;
      w_grant_cpu  = 1'b0;
      w_start_ok   = 1'b0;
      oRomAddress  = iCpuAddress;

      if (w_dump_req && (!iCpuReq || (r_starve == L_MAX_STALL))) begin
         w_grant_dump = 1'b1;
         oRomAddress  = r_dump_ptr;
      end else if (iCpuReq) begin
         w_grant_cpu = 1'b1;
      end

      case (r_state)
         IDLE: begin
            if (iDumpStart) begin
               w_start_ok   = 1'b1;
               w_state_next = (iDumpCount != '0) ? RUN : FINISH;
            end
         end
         RUN: begin
            if (w_grant_dump && (r_remaining == ADDR_W'(1)))
               w_state_next = FINISH;
         end
         FINISH:  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // State register, dump pointer/count, starvation counter and output registers.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state      <= IDLE;
         r_starve     <= '0;
         r_dump_ptr   <= '0;
         r_remaining  <= '0;
         r_cpu_instr  <= '0;
         r_cpu_valid  <= 1'b0;
         r_dump_data  <= '0;
         r_dump_addr  <= '0;
         r_dump_valid <= 1'b0;
         r_dump_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;

         // Counter only runs while the dump side is requesting and losing.
         if (w_grant_dump || !w_dump_req)
            r_starve <= '0;
         else if (iCpuReq)
            r_starve <= r_starve + 4'd1;

         if (w_start_ok) begin
            r_dump_ptr  <= iDumpBase;
            r_remaining <= iDumpCount;
         end else if (w_grant_dump) begin
            r_dump_ptr  <= r_dump_ptr + ADDR_W'(1);
            r_remaining <= r_remaining - ADDR_W'(1);
         end

         r_cpu_valid <= w_grant_cpu;
         if (w_grant_cpu)
            r_cpu_instr <= iRomInstruction;

         r_dump_valid <= w_grant_dump;
         if (w_grant_dump) begin
            r_dump_data <= iRomInstruction;
            r_dump_addr <= r_dump_ptr;
         end

         // Done pulses in the cycle after FINISH is entered.
         r_dump_done <= (r_state == FINISH);
      end
   end

`ifdef ROM_DUMP_CHECKSUM_EN
   logic [15:0] r_checksum;
   logic [15:0] w_word_sum;

   // Per-word checksum term: upper 12 bits zero-extended XOR lower 16 bits.
   always_comb begin
      w_word_sum = {4'h0, iRomInstruction[27:16]} ^ iRomInstruction[15:0];
   end

   // Accumulator cleared on an accepted start, summed on every dump grant.
   always_ff @(posedge Clock) begin
      if (Reset)
         r_checksum <= '0;
      else if (w_start_ok)
         r_checksum <= '0;
      else if (w_grant_dump)
         r_checksum <= r_checksum + w_word_sum;
   end

   assign oDumpChecksum = r_checksum;
`else
   assign oDumpChecksum = 16'h0000;
`endif

   assign oCpuInstruction = r_cpu_instr;
   assign oCpuValid       = r_cpu_valid;
   assign oCpuStall       = iCpuReq && !w_grant_cpu;
   assign oDumpData       = r_dump_data;
   assign oDumpAddress    = r_dump_addr;
   assign oDumpValid      = r_dump_valid;
   assign oDumpBusy       = (r_state == RUN);
   assign oDumpDone       = r_dump_done;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed self-checking bench for rom_fetch_arbiter. The ROM model returns
// {12'hA5A, address}. Build with +define+ROM_DUMP_CHECKSUM_EN to also check
// the dump checksum value.
module tb_rom_fetch_arbiter;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        iCpuReq;
   logic [15:0] iCpuAddress;
   logic [27:0] oCpuInstruction;
   logic        oCpuValid;
   logic        oCpuStall;
   logic        iDumpStart;
   logic [15:0] iDumpBase;
   logic [15:0] iDumpCount;
   logic [27:0] oDumpData;
   logic [15:0] oDumpAddress;
   logic        oDumpValid;
   logic        oDumpBusy;
   logic        oDumpDone;
   logic [15:0] oDumpChecksum;
   logic [15:0] oRomAddress;
   logic [27:0] iRomInstruction;

   int n_cmp = 0;
   int n_err = 0;

   always #5 Clock = ~Clock;

   assign iRomInstruction = {12'hA5A, oRomAddress};

   rom_fetch_arbiter #(.ADDR_W(16), .DATA_W(28), .MAX_STALL(4)) dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .iCpuReq        (iCpuReq),
      .iCpuAddress    (iCpuAddress),
      .oCpuInstruction(oCpuInstruction),
      .oCpuValid      (oCpuValid),
      .oCpuStall      (oCpuStall),
      .iDumpStart     (iDumpStart),
      .iDumpBase      (iDumpBase),
      .iDumpCount     (iDumpCount),
      .oDumpData      (oDumpData),
      .oDumpAddress   (oDumpAddress),
      .oDumpValid     (oDumpValid),
      .oDumpBusy      (oDumpBusy),
      .oDumpDone      (oDumpDone),
      .oDumpChecksum  (oDumpChecksum),
      .oRomAddress    (oRomAddress),
      .iRomInstruction(iRomInstruction)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end else begin
         $display("  ok %s = %h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic start_dump(input logic [15:0] base, input logic [15:0] count);
      iDumpStart = 1'b1;
      iDumpBase  = base;
      iDumpCount = count;
      tick();
      iDumpStart = 1'b0;
   endtask

   logic [15:0] cpu_addr;
   logic [15:0] exp_sum;
   logic [15:0] wrap_addr [3];
   int          words;
   logic        seen_done;

   initial begin
      Reset       = 1'b1;
      iCpuReq     = 1'b0;
      iCpuAddress = '0;
      iDumpStart  = 1'b0;
      iDumpBase   = '0;
      iDumpCount  = '0;
      tick();
      tick();

      // Reset state
      check("rst_cpu_valid", 32'(oCpuValid), 32'd0);
      check("rst_cpu_instr", 32'(oCpuInstruction), 32'd0);
      check("rst_dump_valid", 32'(oDumpValid), 32'd0);
      check("rst_dump_busy", 32'(oDumpBusy), 32'd0);
      check("rst_dump_done", 32'(oDumpDone), 32'd0);
      check("rst_checksum", 32'(oDumpChecksum), 32'd0);
      Reset = 1'b0;
      tick();

      // Reset asserted for 2 cycles in the middle of a dump
      start_dump(16'h0050, 16'd8);
      tick();
      check("mid_valid_before_rst", 32'(oDumpValid), 32'd1);
      Reset = 1'b1;
      tick();
      tick();
      check("midrst_dump_valid", 32'(oDumpValid), 32'd0);
      check("midrst_dump_data", 32'(oDumpData), 32'd0);
      check("midrst_dump_addr", 32'(oDumpAddress), 32'd0);
      check("midrst_busy", 32'(oDumpBusy), 32'd0);
      check("midrst_checksum", 32'(oDumpChecksum), 32'd0);
      Reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("midrst_no_done", 32'(oDumpDone), 32'd0);
         check("midrst_idle", 32'(oDumpBusy), 32'd0);
      end

      // CPU back-to-back fetches 0..7, no dump
      for (int i = 0; i < 8; i++) begin
         iCpuReq     = 1'b1;
         iCpuAddress = 16'(i);
         #1;
         check("cpu_stall", 32'(oCpuStall), 32'd0);
         tick();
         check("cpu_valid", 32'(oCpuValid), 32'd1);
         check("cpu_instr", 32'(oCpuInstruction), 32'h0A5A0000 + 32'(i));
      end
      iCpuReq = 1'b0;
      tick();
      check("cpu_valid_idle", 32'(oCpuValid), 32'd0);

      // Dump base 0x0010, count 3, CPU idle
      start_dump(16'h0010, 16'd3);
      check("d3_busy", 32'(oDumpBusy), 32'd1);
      check("d3_valid_lat", 32'(oDumpValid), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("d3_valid", 32'(oDumpValid), 32'd1);
         check("d3_addr", 32'(oDumpAddress), 32'h10 + 32'(k));
         check("d3_data", 32'(oDumpData), 32'h0A5A0010 + 32'(k));
         check("d3_no_done", 32'(oDumpDone), 32'd0);
      end
      tick();
      check("d3_done", 32'(oDumpDone), 32'd1);
      check("d3_valid_end", 32'(oDumpValid), 32'd0);
      check("d3_busy_end", 32'(oDumpBusy), 32'd0);
      check("d3_addr_hold", 32'(oDumpAddress), 32'h12);
`ifdef ROM_DUMP_CHECKSUM_EN
      exp_sum = (16'h0A5A ^ 16'h0010) + (16'h0A5A ^ 16'h0011) + (16'h0A5A ^ 16'h0012);
`else
      exp_sum = 16'h0000;
`endif
      check("d3_checksum", 32'(oDumpChecksum), 32'(exp_sum));
      tick();
      check("d3_done_pulse", 32'(oDumpDone), 32'd0);

      // Dump count 8 against a continuously requesting CPU
      start_dump(16'h0200, 16'd8);
      cpu_addr = 16'h0100;
      words    = 0;
      for (int j = 1; j <= 40; j++) begin
         iCpuReq     = 1'b1;
         iCpuAddress = cpu_addr;
         #1;
         check("st_stall", 32'(oCpuStall), (j % 5 == 0) ? 32'd1 : 32'd0);
         tick();
         words += int'(oDumpValid);
         if (j % 5 == 0) begin
            check("st_cpu_valid_off", 32'(oCpuValid), 32'd0);
            check("st_dump_valid", 32'(oDumpValid), 32'd1);
            check("st_dump_addr", 32'(oDumpAddress), 32'h200 + 32'(j / 5 - 1));
         end else begin
            check("st_cpu_valid", 32'(oCpuValid), 32'd1);
            check("st_cpu_instr", 32'(oCpuInstruction), {4'h0, 12'hA5A, cpu_addr});
            check("st_dump_valid_off", 32'(oDumpValid), 32'd0);
            cpu_addr = cpu_addr + 16'd1;
         end
      end
      iCpuReq   = 1'b0;
      seen_done = 1'b0;
      for (int k = 0; k < 4 && !seen_done; k++) begin
         tick();
         words += int'(oDumpValid);
         if (oDumpDone) seen_done = 1'b1;
      end
      check("st_done_seen", 32'(seen_done), 32'd1);
      check("st_words", 32'(words), 32'd8);
      tick();

      // Address wrap at the top of the ROM
      wrap_addr[0] = 16'hFFFE;
      wrap_addr[1] = 16'hFFFF;
      wrap_addr[2] = 16'h0000;
      start_dump(16'hFFFE, 16'd3);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("wr_valid", 32'(oDumpValid), 32'd1);
         check("wr_addr", 32'(oDumpAddress), 32'(wrap_addr[k]));
         check("wr_data", 32'(oDumpData), {4'h0, 12'hA5A, wrap_addr[k]});
      end
      tick();
      check("wr_done", 32'(oDumpDone), 32'd1);
      tick();

      // Zero-count start: no data, done two cycles after the start
      start_dump(16'h0020, 16'd0);
      check("z_busy", 32'(oDumpBusy), 32'd0);
      check("z_valid", 32'(oDumpValid), 32'd0);
      check("z_done_early", 32'(oDumpDone), 32'd0);
      tick();
      check("z_done", 32'(oDumpDone), 32'd1);
      check("z_valid2", 32'(oDumpValid), 32'd0);
      tick();

      // Start during RUN is ignored
      start_dump(16'h0030, 16'd2);
      iDumpStart = 1'b1;
      iDumpBase  = 16'h0040;
      iDumpCount = 16'd5;
      tick();
      iDumpStart = 1'b0;
      check("ig_valid0", 32'(oDumpValid), 32'd1);
      check("ig_addr0", 32'(oDumpAddress), 32'h30);
      tick();
      check("ig_valid1", 32'(oDumpValid), 32'd1);
      check("ig_addr1", 32'(oDumpAddress), 32'h31);
      tick();
      check("ig_no_third", 32'(oDumpValid), 32'd0);
      check("ig_done", 32'(oDumpDone), 32'd1);
      tick();
      check("ig_idle", 32'(oDumpBusy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
